wb_trace_recorder: RTL and testbench
====================================

Name: wb_trace_recorder

Overview:
- Observation-side counterpart to the CPU stimulus bench: the bench drives clk/reset into the pipelined MIPS core; this block receives the core's architectural write events (GRF write-back, DM store), queues them, and streams them out one record at a time for the auto-judge comparator.
- Sits beside the mips top and taps the WB-stage GRF write port and the MEM-stage DM write port.
- Buffers bursts so a slow consumer never stalls the CPU, and flags any loss.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 4.
SKIP_ZERO, 1, when 1, GRF writes to register 0 are not recorded.

Ports:
clk  in  1  single system clock, rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset asserted).
grf_we  in  1  GRF write strobe, WB stage.
grf_pc  in  32  PC of the writing instruction.
grf_addr  in  5  destination register.
grf_wdata  in  32  value written.
dm_we  in  1  DM store strobe, MEM stage.
dm_pc  in  32  PC of the storing instruction.
dm_addr  in  32  byte address of the store.
dm_wdata  in  32  store data.
rec_valid  out  1  a record is presented.
rec_ready  in  1  consumer accepts the record.
rec_kind  out  1  0 = GRF record, 1 = DM record.
rec_pc  out  32  record PC.
rec_addr  out  32  GRF: zero-extended register number; DM: byte address.
rec_data  out  32  written value.
overflow  out  1  sticky; set when any event was dropped.
drop_cnt  out  16  number of dropped events, saturates at 16'hFFFF.
rec_cnt  out  32  records accepted by the consumer, wraps modulo 2^32.

Behaviour:
- Reset (reset=0, async):
  - FIFO emptied; read and write pointers set to 0.
  - rec_valid=0; rec_kind, rec_pc, rec_addr, rec_data = 0.
  - overflow=0, drop_cnt=0, rec_cnt=0.
  - Reset mid-stream discards all queued records; no partial record survives.
- Event qualification, sampled each rising edge:
  - GRF event = grf_we & !(SKIP_ZERO & grf_addr==0).
  - DM event = dm_we.
- Push:
  - Up to 2 entries per cycle.
  - When both events occur in the same cycle, the GRF entry is written first (it belongs to the older instruction in WB), then the DM entry.
  - Entry fields: {kind, pc, addr, data}.
- Output: FIFO head is presented directly on the rec_* ports.
  - rec_valid = (occupancy != 0).
  - Push-to-visible latency is 1 cycle: an event at edge N makes rec_valid=1 after edge N when the FIFO was empty.
  - No bypass from input to output in the same cycle.
- Handshake:
  - A record pops on a rising edge where rec_valid & rec_ready.
  - rec_* fields are stable while rec_valid=1 and rec_ready=0.
  - rec_ready while rec_valid=0 has no effect.
- Capacity per edge: free = DEPTH - occupancy + pop, where pop is 0 or 1. A pop in the same cycle frees its slot for that cycle's pushes.
- Overflow:
  - Events that do not fit are dropped. GRF has priority: with free=1 and both events present, GRF is kept and DM is dropped.
  - Each dropped event increments drop_cnt by 1 (two drops in one cycle add 2), saturating.
  - overflow sets on the first drop and stays set until reset.
- Occupancy update: occupancy_next = occupancy + pushes_kept - pop, range 0..DEPTH.
- Pointers wrap modulo DEPTH. Full (occupancy=DEPTH) and empty (occupancy=0) are distinguished by an explicit occupancy counter, not by pointer equality alone.
- rec_cnt increments on every pop.
- rec_cnt and drop_cnt are registered; they change only on rising edges.

Test Plan:
- Reset then idle:
  - Stimulus: reset=0 for 3 cycles, release, no strobes.
  - Required: rec_valid=0, overflow=0, drop_cnt=0, rec_cnt=0 throughout.
- Single GRF write:
  - Stimulus: grf_we=1, pc=0x3000, addr=8, data=0x1234 for one cycle; rec_ready=1.
  - Required: next cycle rec_valid=1, kind=0, pc=0x3000, addr=8, data=0x1234. Popped on the following edge; rec_cnt=1.
- Simultaneous GRF and DM:
  - Stimulus: in one cycle, GRF (pc=0x3004, addr=9, data=5) and DM (pc=0x3008, addr=0x10, data=7); rec_ready=1.
  - Required: GRF record appears first, DM record the next cycle.
- Register 0 filter:
  - Stimulus: grf_we=1, addr=0, with SKIP_ZERO=1.
  - Required: no record.
  - Repeat with SKIP_ZERO=0: one record with addr=0.
- Fill and overflow:
  - Stimulus: rec_ready=0; 8 cycles of dual events (16 entries); then 1 more dual-event cycle.
  - Required: both new events dropped; overflow=1, drop_cnt=2. Draining yields exactly 16 records in push order.
- Backpressure and reset mid-operation:
  - Stimulus: toggle rec_ready with pattern 1010 while pushing 6 GRF events; assert reset after 3 pops.
  - Required: fields stable while stalled; on reset, rec_valid=0 immediately (asynchronously) and rec_cnt=0.

Source files
------------

// File: rtl/wb_trace_recorder.sv
// wb_trace_recorder
// -----------------
// Captures the architectural write events of the pipelined MIPS core and
// streams them to the judge comparator one record at a time. It watches the
// WB-stage GRF write port and the MEM-stage DM store port, queues up to two
// events per cycle in a FIFO, and flags any event that had to be dropped.
//
// Ports
//   clk, reset          : rising-edge clock, asynchronous active-low reset
//   grf_we/pc/addr/wdata: GRF write-back event (WB stage)
//   dm_we/pc/addr/wdata : DM store event (MEM stage)
//   rec_valid/ready     : output record handshake
//   rec_kind/pc/addr/data : FIFO head (kind 0 = GRF, 1 = DM)
//   overflow            : sticky, set once any event is dropped
//   drop_cnt            : dropped events, saturating at 16'hFFFF
//   rec_cnt             : records accepted by the consumer, wrapping
//
// Handshake: rec_valid is high whenever the FIFO holds at least one record
// and does not depend on rec_ready. A record transfers on every rising edge
// where rec_valid and rec_ready are both high; while rec_valid is high and
// rec_ready is low the rec_* fields hold steady. rec_ready with rec_valid low
// is ignored.

module wb_trace_recorder #(
    parameter int DEPTH     = 16,
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        grf_we,
    input  logic [31:0] grf_pc,
    input  logic [4:0]  grf_addr,
    input  logic [31:0] grf_wdata,
    input  logic        dm_we,
    input  logic [31:0] dm_pc,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        rec_valid,
    input  logic        rec_ready,
    output logic        rec_kind,
    output logic [31:0] rec_pc,
    output logic [31:0] rec_addr,
    output logic [31:0] rec_data,
    output logic        overflow,
    output logic [15:0] drop_cnt,
    output logic [31:0] rec_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW+1:0] FREE_ONE = (AW+2)'(1);
    localparam logic [AW+1:0] FREE_TWO = (AW+2)'(2);
    localparam logic [AW+1:0] FREE_ALL = (AW+2)'(DEPTH);

    // Entry storage, one array per record field.
    logic        mem_kind [DEPTH];
    logic [31:0] mem_pc   [DEPTH];
    logic [31:0] mem_addr [DEPTH];
    logic [31:0] mem_data [DEPTH];

    // Explicit occupancy counter separates full from empty.
    logic [AW:0]   count;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    logic          grf_ev;
    logic          dm_ev;
    logic          pop;
    logic [AW+1:0] free;
    logic          grf_keep;
    logic          dm_keep;
    logic [1:0]    drops;
    logic [AW-1:0] dm_slot;
    logic [16:0]   drop_sum;

    assign rec_valid = (count != '0);

    always_comb begin
        grf_ev   = grf_we && !(SKIP_ZERO && (grf_addr == 5'd0));
        dm_ev    = dm_we;
        pop      = rec_valid && rec_ready;
        // A pop on this edge releases its slot to this edge's pushes.
        free     = FREE_ALL - {1'b0, count} + (AW+2)'(pop);
        // GRF belongs to the older instruction, so it claims space first.
        grf_keep = grf_ev && (free >= FREE_ONE);
        dm_keep  = dm_ev && (free >= (grf_keep ? FREE_TWO : FREE_ONE));
        drops    = 2'(grf_ev && !grf_keep) + 2'(dm_ev && !dm_keep);
        dm_slot  = grf_keep ? wr_ptr + 1'b1 : wr_ptr;
        drop_sum = {1'b0, drop_cnt} + 17'(drops);
    end

    // Head is presented straight from storage; forced to zero when empty so
    // that no stale entry is visible after reset or drain.
    always_comb begin
        rec_kind = 1'b0;
        rec_pc   = '0;
        rec_addr = '0;
        rec_data = '0;
        if (rec_valid) begin
            rec_kind = mem_kind[rd_ptr];
            rec_pc   = mem_pc[rd_ptr];
            rec_addr = mem_addr[rd_ptr];
            rec_data = mem_data[rd_ptr];
        end
    end

    // Storage needs no reset: unoccupied entries are never presented.
    always_ff @(posedge clk) begin
        if (grf_keep) begin
            mem_kind[wr_ptr] <= 1'b0;
            mem_pc[wr_ptr]   <= grf_pc;
            mem_addr[wr_ptr] <= {27'd0, grf_addr};
            mem_data[wr_ptr] <= grf_wdata;
        end
        if (dm_keep) begin
            mem_kind[dm_slot] <= 1'b1;
            mem_pc[dm_slot]   <= dm_pc;
            mem_addr[dm_slot] <= dm_addr;
            mem_data[dm_slot] <= dm_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
            rec_cnt  <= '0;
        end else begin
            count  <= count + (AW+1)'(grf_keep) + (AW+1)'(dm_keep) - (AW+1)'(pop);
            wr_ptr <= wr_ptr + AW'(grf_keep) + AW'(dm_keep);
            rd_ptr <= rd_ptr + AW'(pop);
            if (pop) begin
                rec_cnt <= rec_cnt + 32'd1;
            end
            if (drops != 2'd0) begin
                overflow <= 1'b1;
                drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            end
        end
    end

endmodule

// File: tb/tb_wb_trace_recorder.sv
// Directed bench for wb_trace_recorder. Inputs change and outputs are sampled
// on the falling clock edge; the DUT acts on the rising edge.
// A second instance with SKIP_ZERO=0 is driven only during the register-0
// filter step through its own GRF strobe.

module tb_wb_trace_recorder;

    logic        clk = 1'b0;
    logic        reset;
    logic        grf_we, grf_we1;
    logic [31:0] grf_pc;
    logic [4:0]  grf_addr;
    logic [31:0] grf_wdata;
    logic        dm_we;
    logic [31:0] dm_pc, dm_addr, dm_wdata;
    logic        rec_ready;

    logic        rec_valid, rec_kind, overflow;
    logic [31:0] rec_pc, rec_addr, rec_data, rec_cnt;
    logic [15:0] drop_cnt;

    logic        rec_valid1, rec_kind1, overflow1;
    logic [31:0] rec_pc1, rec_addr1, rec_data1, rec_cnt1;
    logic [15:0] drop_cnt1;

    int n_assert = 0;
    int n_fail   = 0;

    // Scoreboard: expected records, {kind, pc, addr, data}.
    logic [96:0] exp_q[$];
    logic [96:0] exp_rec;

    always #5 clk = ~clk;

    wb_trace_recorder #(.DEPTH(16), .SKIP_ZERO(1'b1)) dut (
        .clk(clk), .reset(reset),
        .grf_we(grf_we), .grf_pc(grf_pc), .grf_addr(grf_addr), .grf_wdata(grf_wdata),
        .dm_we(dm_we), .dm_pc(dm_pc), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_kind(rec_kind),
        .rec_pc(rec_pc), .rec_addr(rec_addr), .rec_data(rec_data),
        .overflow(overflow), .drop_cnt(drop_cnt), .rec_cnt(rec_cnt)
    );

    wb_trace_recorder #(.DEPTH(16), .SKIP_ZERO(1'b0)) dut_nz (
        .clk(clk), .reset(reset),
        .grf_we(grf_we1), .grf_pc(grf_pc), .grf_addr(grf_addr), .grf_wdata(grf_wdata),
        .dm_we(1'b0), .dm_pc(dm_pc), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .rec_valid(rec_valid1), .rec_ready(1'b1), .rec_kind(rec_kind1),
        .rec_pc(rec_pc1), .rec_addr(rec_addr1), .rec_data(rec_data1),
        .overflow(overflow1), .drop_cnt(drop_cnt1), .rec_cnt(rec_cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        grf_we = 1'b0; grf_we1 = 1'b0; dm_we = 1'b0;
    endtask

    task automatic drive_grf(input logic [31:0] pc, input logic [4:0] a, input logic [31:0] d);
        grf_we = 1'b1; grf_pc = pc; grf_addr = a; grf_wdata = d;
    endtask

    task automatic drive_dm(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] d);
        dm_we = 1'b1; dm_pc = pc; dm_addr = a; dm_wdata = d;
    endtask

    task automatic chk_head(input string tag, input logic [96:0] e);
        chk({tag, "_valid"}, 32'(rec_valid), 32'd1);
        chk({tag, "_kind"}, 32'(rec_kind), 32'(e[96]));
        chk({tag, "_pc"}, rec_pc, e[95:64]);
        chk({tag, "_addr"}, rec_addr, e[63:32]);
        chk({tag, "_data"}, rec_data, e[31:0]);
    endtask

    initial begin
        reset = 1'b0; rec_ready = 1'b0;
        grf_pc = '0; grf_addr = '0; grf_wdata = '0;
        dm_pc = '0; dm_addr = '0; dm_wdata = '0;
        idle();

        // Reset then idle
        repeat (3) tick();
        chk("rst_valid", 32'(rec_valid), 32'd0);
        chk("rst_pc", rec_pc, 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_cnt", rec_cnt, 32'd0);
        reset = 1'b1;
        repeat (2) tick();
        chk("idle_valid", 32'(rec_valid), 32'd0);
        chk("idle_ovf", 32'(overflow), 32'd0);
        chk("idle_drop", 32'(drop_cnt), 32'd0);
        chk("idle_cnt", rec_cnt, 32'd0);

        // Single GRF write
        rec_ready = 1'b1;
        drive_grf(32'h3000, 5'd8, 32'h1234);
        tick(); idle();
        chk_head("grf1", {1'b0, 32'h3000, 32'd8, 32'h1234});
        chk("grf1_cnt_before", rec_cnt, 32'd0);
        tick();
        chk("grf1_valid_after", 32'(rec_valid), 32'd0);
        chk("grf1_cnt", rec_cnt, 32'd1);

        // Simultaneous GRF and DM: GRF first
        drive_grf(32'h3004, 5'd9, 32'd5);
        drive_dm(32'h3008, 32'h10, 32'd7);
        tick(); idle();
        chk_head("dual_grf", {1'b0, 32'h3004, 32'd9, 32'd5});
        tick();
        chk_head("dual_dm", {1'b1, 32'h3008, 32'h10, 32'd7});
        chk("dual_cnt_mid", rec_cnt, 32'd2);
        tick();
        chk("dual_empty", 32'(rec_valid), 32'd0);
        chk("dual_cnt", rec_cnt, 32'd3);

        // Register 0 filter: filtered with SKIP_ZERO=1, recorded with SKIP_ZERO=0
        drive_grf(32'h300c, 5'd0, 32'hAA);
        grf_we1 = 1'b1;
        tick(); idle();
        chk("r0_skip_valid", 32'(rec_valid), 32'd0);
        chk("r0_keep_valid", 32'(rec_valid1), 32'd1);
        chk("r0_keep_addr", rec_addr1, 32'd0);
        chk("r0_keep_pc", rec_pc1, 32'h300c);
        chk("r0_keep_data", rec_data1, 32'hAA);
        tick();
        chk("r0_keep_popped", 32'(rec_valid1), 32'd0);
        chk("r0_keep_cnt", rec_cnt1, 32'd1);
        chk("r0_skip_cnt", rec_cnt, 32'd3);

        // Fill with 8 dual-event cycles, then one more that must be dropped
        rec_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive_grf(32'h4000 + 32'(8 * i), 5'(i + 1), 32'h100 + 32'(i));
            drive_dm(32'h4004 + 32'(8 * i), 32'h2000 + 32'(4 * i), 32'h200 + 32'(i));
            exp_q.push_back({1'b0, 32'h4000 + 32'(8 * i), 32'(i + 1), 32'h100 + 32'(i)});
            exp_q.push_back({1'b1, 32'h4004 + 32'(8 * i), 32'h2000 + 32'(4 * i), 32'h200 + 32'(i)});
            tick();
        end
        idle();
        chk("full_ovf", 32'(overflow), 32'd0);
        chk("full_drop", 32'(drop_cnt), 32'd0);
        drive_grf(32'h5000, 5'd31, 32'hDEAD);
        drive_dm(32'h5004, 32'h3000, 32'hBEEF);
        tick(); idle();
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_drop", 32'(drop_cnt), 32'd2);
        chk("ovf_head_pc", rec_pc, 32'h4000);

        // Drain; the first drain edge also carries a dual event. The pop
        // frees one slot, so GRF is kept and DM dropped.
        rec_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            if (exp_q.size() == 0) begin
                chk("drain_underrun", 32'd1, 32'd0);
                break;
            end
            exp_rec = exp_q.pop_front();
            chk_head("drain", exp_rec);
            if (i == 0) begin
                drive_grf(32'h6000, 5'd3, 32'h6);
                drive_dm(32'h6004, 32'h4000, 32'h66);
                exp_q.push_back({1'b0, 32'h6000, 32'd3, 32'h6});
            end else begin
                idle();
            end
            tick();
        end
        idle();
        chk("drain_empty", 32'(rec_valid), 32'd0);
        chk("drain_drop", 32'(drop_cnt), 32'd3);
        chk("drain_ovf", 32'(overflow), 32'd1);
        chk("drain_cnt", rec_cnt, 32'd20);
        chk("drain_q", 32'(exp_q.size()), 32'd0);

        // Backpressure: ready pattern 1010... while pushing 6 GRF events
        exp_q.delete();
        for (int k = 0; k < 7; k++) begin
            if (exp_q.size() != 0) begin
                chk_head("bp", exp_q[0]);
            end else begin
                chk("bp_empty", 32'(rec_valid), 32'd0);
            end
            rec_ready = (k % 2 == 0);
            if (rec_ready && exp_q.size() != 0) begin
                exp_rec = exp_q.pop_front();
            end
            if (k < 6) begin
                drive_grf(32'h7000 + 32'(4 * k), 5'(10 + k), 32'h7700 + 32'(k));
                exp_q.push_back({1'b0, 32'h7000 + 32'(4 * k), 32'(10 + k), 32'h7700 + 32'(k)});
            end else begin
                idle();
            end
            tick();
        end
        idle();
        rec_ready = 1'b0;
        chk("bp_cnt", rec_cnt, 32'd23);
        chk_head("bp_head", {1'b0, 32'h700c, 32'd13, 32'h7703});

        // Asynchronous reset mid-stream
        #2 reset = 1'b0;
        #1;
        chk("arst_valid", 32'(rec_valid), 32'd0);
        chk("arst_cnt", rec_cnt, 32'd0);
        chk("arst_ovf", 32'(overflow), 32'd0);
        chk("arst_drop", 32'(drop_cnt), 32'd0);
        chk("arst_pc", rec_pc, 32'd0);
        tick();
        reset = 1'b1;
        rec_ready = 1'b1;
        tick();
        chk("post_rst_valid", 32'(rec_valid), 32'd0);
        chk("post_rst_cnt", rec_cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
